// File: rtl/pwm_dc_modulator.sv
// Complementary PWM gate driver with dead time, period-aligned duty loading
// and a divided calc strobe that paces the upstream duty controller.
`timescale 1ns/1ps
module pwm_dc_modulator #(
  parameter int CNT_W      = 16,
  parameter int PERIOD_CNT = 500,
  parameter int DEADTIME   = 10,
  parameter int CALC_DIV   = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [31:0]      i_DC_control,
  input  logic             i_DV,
  output logic             o_pwm_hi,
  output logic             o_pwm_lo,
  output logic             o_calc_DV,
  output logic             o_period_start,
  output logic [CNT_W-1:0] o_cmp,
  output logic             o_dc_sat
);

  localparam int DT_W = $clog2(DEADTIME) + 1;
  localparam int PD_W = $clog2(CALC_DIV) + 1;
  localparam int PW   = 17 + CNT_W;

  localparam logic [CNT_W-1:0] LP_PER  = CNT_W'(PERIOD_CNT);
  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(PERIOD_CNT - 1);
  localparam logic [CNT_W-1:0] LP_HALF = CNT_W'(PERIOD_CNT / 2);
  localparam logic [DT_W-1:0]  LP_DT_LAST = DT_W'(DEADTIME - 1);
  localparam logic [PD_W-1:0]  LP_PD_LAST = PD_W'(CALC_DIV - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DT_HI = 3'd1;
  localparam logic [2:0] S_DT_LO = 3'd2;
  localparam logic [2:0] S_ON_HI = 3'd3;
  localparam logic [2:0] S_ON_LO = 3'd4;

  logic [16:0]      r_s1_val;
  logic             r_s1_vld;
  logic [CNT_W-1:0] r_pend_cmp;
  logic             r_pending;
  logic [CNT_W-1:0] r_cmp;
  logic [CNT_W-1:0] r_cnt;
  logic [PD_W-1:0]  r_pdiv;
  logic [DT_W-1:0]  r_dt;
  logic [2:0]       r_state;
  logic             r_hi;
  logic             r_lo;
  logic             r_sat;

  logic             w_neg;
  logic             w_over;
  logic [16:0]      w_clamp;
  logic [PW-1:0]    w_prod;
  logic [CNT_W-1:0] w_s2_cmp;
  logic             w_load_ok;
  logic [CNT_W-1:0] w_load_val;
  logic [CNT_W-1:0] w_entry_cmp;
  logic             w_run;
  logic             w_wrap;
  logic             w_do_load;
  logic             w_raw;
  logic             w_raw0;
  logic [2:0]       w_nstate;
  logic [DT_W-1:0]  w_dt_nxt;

  assign w_neg   = i_DC_control[31];
  assign w_over  = !w_neg && (i_DC_control > 32'h0001_0000);
  assign w_clamp = w_neg  ? 17'h0_0000 :
                   w_over ? 17'h1_0000 : i_DC_control[16:0];

  assign w_prod   = PW'(r_s1_val) * PW'(LP_PER);
  assign w_s2_cmp = CNT_W'(w_prod >> 16);

  // A value finishing S2 this cycle wins over an older pending one
  assign w_load_ok   = r_s1_vld | r_pending;
  assign w_load_val  = r_s1_vld ? w_s2_cmp : r_pend_cmp;
  assign w_entry_cmp = w_load_ok ? w_load_val : r_cmp;

  assign w_run  = (r_state != S_IDLE);
  assign w_wrap = w_run && i_en && (r_cnt == LP_LAST);
  assign w_do_load = w_load_ok &&
                     (w_wrap || (!w_run && i_en));

  assign w_raw  = (r_cnt < r_cmp);
  assign w_raw0 = (w_entry_cmp != '0);

  always_comb begin
    w_nstate = r_state;
    w_dt_nxt = r_dt;
    if (!i_en) begin
      w_nstate = S_IDLE;
      w_dt_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_nstate = w_raw0 ? S_DT_HI : S_DT_LO;
          w_dt_nxt = '0;
        end
        S_ON_HI: if (!w_raw) begin
          w_nstate = S_DT_LO;
          w_dt_nxt = '0;
        end
        S_ON_LO: if (w_raw) begin
          w_nstate = S_DT_HI;
          w_dt_nxt = '0;
        end
        S_DT_HI: begin
          if (!w_raw) begin
            w_nstate = S_DT_LO;
            w_dt_nxt = '0;
          end else if (r_dt == LP_DT_LAST) begin
            w_nstate = S_ON_HI;
            w_dt_nxt = '0;
          end else begin
            w_dt_nxt = r_dt + DT_W'(1);
          end
        end
        S_DT_LO: begin
          if (w_raw) begin
            w_nstate = S_DT_HI;
            w_dt_nxt = '0;
          end else if (r_dt == LP_DT_LAST) begin
            w_nstate = S_ON_LO;
            w_dt_nxt = '0;
          end else begin
            w_dt_nxt = r_dt + DT_W'(1);
          end
        end
        default: begin
          w_nstate = S_IDLE;
          w_dt_nxt = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1_val   <= '0;
      r_s1_vld   <= 1'b0;
      r_pend_cmp <= '0;
      r_pending  <= 1'b0;
      r_cmp      <= '0;
      r_cnt      <= '0;
      r_pdiv     <= '0;
      r_dt       <= '0;
      r_state    <= S_IDLE;
      r_hi       <= 1'b0;
      r_lo       <= 1'b0;
      r_sat      <= 1'b0;
    end else begin
      r_s1_vld <= i_DV;
      if (i_DV) begin
        r_s1_val <= w_clamp;
        if (w_neg || w_over) r_sat <= 1'b1;
      end
      if (r_s1_vld) r_pend_cmp <= w_s2_cmp;
      if (w_do_load) begin
        r_cmp     <= w_load_val;
        r_pending <= 1'b0;
      end else if (r_s1_vld) begin
        r_pending <= 1'b1;
      end
      r_state <= w_nstate;
      r_dt    <= w_dt_nxt;
      r_hi    <= (w_nstate == S_ON_HI);
      r_lo    <= (w_nstate == S_ON_LO);
      if (!i_en || !w_run) begin
        r_cnt  <= '0;
        r_pdiv <= '0;
      end else if (w_wrap) begin
        r_cnt  <= '0;
        r_pdiv <= (r_pdiv == LP_PD_LAST) ? '0 : r_pdiv + PD_W'(1);
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_pwm_hi       = r_hi;
  assign o_pwm_lo       = r_lo;
  assign o_cmp          = r_cmp;
  assign o_dc_sat       = r_sat;
  assign o_period_start = w_run && (r_cnt == '0);
  assign o_calc_DV      = w_run && (r_cnt == LP_HALF) &&
                          (r_pdiv == LP_PD_LAST);

endmodule

// File: tb/tb_pwm_dc_modulator.sv
// Directed bench for pwm_dc_modulator: duty loading, clamping, dead time,
// calc strobe spacing, enable drop and asynchronous reset.
`timescale 1ns/1ps
module tb_pwm_dc_modulator;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] dc;
  logic        dv;
  logic        hi;
  logic        lo;
  logic        calc;
  logic        ps;
  logic [15:0] cmp;
  logic        sat;

  int n_tests = 0;
  int n_fail  = 0;
  bit seen125 = 0;

  pwm_dc_modulator dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_en(en),
    .i_DC_control(dc),
    .i_DV(dv),
    .o_pwm_hi(hi),
    .o_pwm_lo(lo),
    .o_calc_DV(calc),
    .o_period_start(ps),
    .o_cmp(cmp),
    .o_dc_sat(sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      assert (!(hi && lo)) else begin
        n_fail++;
        $error("FAIL overlap: observed hi=%0b lo=%0b required not both", hi, lo);
      end
    end
    if (cmp == 16'd125) seen125 = 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic dvp(input logic [31:0] v);
    dc = v;
    dv = 1'b1;
    @(negedge clk);
    dv = 1'b0;
  endtask

  task automatic wait_cmp(input logic [15:0] v, input string tag);
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      if (cmp == v && ps) ok = 1;
      else @(negedge clk);
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic measure(output int nh, output int nl,
                         output int fh, output int lh, output int fl);
    nh = 0; nl = 0; fh = -1; lh = -1; fl = -1;
    for (int i = 0; i < 500; i++) begin
      if (hi) begin
        nh++;
        if (fh < 0) fh = i;
        lh = i;
      end
      if (lo) begin
        nl++;
        if (fl < 0 && i > 0) fl = i;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    int nh, nl, fh, lh, fl, hsum, k, n;
    bit found;
    rst = 0; en = 0; dc = '0; dv = 0;
    #2 rst = 1;
    repeat (3) @(negedge clk);
    chk("rst_hi", 32'(hi), 32'd0);
    chk("rst_lo", 32'(lo), 32'd0);
    chk("rst_cmp", 32'(cmp), 32'd0);
    chk("rst_ps", 32'(ps), 32'd0);
    chk("rst_calc", 32'(calc), 32'd0);
    chk("rst_sat", 32'(sat), 32'd0);

    rst = 0; en = 1;
    @(negedge clk);
    dvp(32'h0000_8000);
    wait_cmp(16'd250, "t1_load");
    measure(nh, nl, fh, lh, fl);
    chk("t1_nhi", 32'(nh), 32'd240);
    chk("t1_nlo", 32'(nl), 32'd240);
    chk("t1_hi_rise", 32'(fh), 32'd11);
    chk("t1_hi_fall", 32'(lh), 32'd250);
    chk("t1_lo_rise", 32'(fl), 32'd261);

    dvp(32'h0001_0000);
    wait_cmp(16'd500, "t2_load500");
    measure(nh, nl, fh, lh, fl);
    chk("t2_first_nhi", 32'(nh), 32'd489);
    chk("t2_first_nlo", 32'(nl), 32'd1);
    measure(nh, nl, fh, lh, fl);
    chk("t2_full_nhi", 32'(nh), 32'd500);
    chk("t2_full_nlo", 32'(nl), 32'd0);
    dvp(32'h0000_0000);
    wait_cmp(16'd0, "t2_load0");
    measure(nh, nl, fh, lh, fl);
    chk("t2_zero_first_nhi", 32'(nh), 32'd1);
    measure(nh, nl, fh, lh, fl);
    chk("t2_zero_nlo", 32'(nl), 32'd500);
    chk("t2_zero_nhi", 32'(nh), 32'd0);
    chk("t2_sat_clear", 32'(sat), 32'd0);

    dvp(32'hFFFF_0000);
    chk("t3_sat_neg", 32'(sat), 32'd1);
    wait_cmp(16'd0, "t3_cmp0");
    dvp(32'h0002_0000);
    wait_cmp(16'd500, "t3_cmp_clamp");
    chk("t3_sat_sticky", 32'(sat), 32'd1);

    seen125 = 0;
    repeat (50) @(negedge clk);
    dvp(32'h0000_4000);
    repeat (5) @(negedge clk);
    dvp(32'h0000_C000);
    repeat (20) @(negedge clk);
    chk("t4_hold", 32'(cmp), 32'd500);
    wait_cmp(16'd375, "t4_last_wins");
    chk("t4_no125", 32'(seen125), 32'd0);

    dvp(32'h0000_0084);
    wait_cmp(16'd1, "t5_cmp1");
    hsum = 0;
    for (int p = 0; p < 3; p++) begin
      measure(nh, nl, fh, lh, fl);
      hsum += nh;
    end
    chk("t5_hi_never", 32'(hsum), 32'd0);
    chk("t5_nlo", 32'(nl), 32'd489);

    found = 0; k = 0;
    for (int i = 0; i < 2100 && !found; i++) begin
      @(negedge clk);
      if (ps) k = 0;
      else k++;
      if (calc) found = 1;
    end
    chk("t6_calc_seen", 32'(found), 32'd1);
    chk("t6_calc_phase", 32'(k), 32'd250);
    @(negedge clk);
    chk("t6_calc_width", 32'(calc), 32'd0);
    n = 1; found = 0;
    while (!found && n < 2100) begin
      @(negedge clk);
      n++;
      if (calc) found = 1;
    end
    chk("t6_calc_interval", 32'(n), 32'd2000);

    dvp(32'h0000_8000);
    wait_cmp(16'd250, "t6_cmp250");
    repeat (100) @(negedge clk);
    chk("t6_on_hi", 32'(hi), 32'd1);
    en = 0;
    @(negedge clk);
    chk("t6_en_hi", 32'(hi), 32'd0);
    chk("t6_en_lo", 32'(lo), 32'd0);
    chk("t6_en_ps", 32'(ps), 32'd0);
    chk("t6_en_cmp_kept", 32'(cmp), 32'd250);
    en = 1;
    @(negedge clk);
    chk("t6_restart_ps", 32'(ps), 32'd1);
    #2 rst = 1;
    #1;
    chk("t6_arst_cmp", 32'(cmp), 32'd0);
    chk("t6_arst_sat", 32'(sat), 32'd0);
    chk("t6_arst_ps", 32'(ps), 32'd0);
    chk("t6_arst_hi", 32'(hi), 32'd0);
    chk("t6_arst_lo", 32'(lo), 32'd0);
    @(negedge clk);
    rst = 0;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
